// File: rtl/boxcar_pkg.sv
// Shared types and width helpers for the boxcar window accumulator.
package boxcar_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int sum_width(input int dw, input int len);
    return dw + $clog2(len + 1);
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/boxcar_fill_cnt.sv
// Saturating enable counter tracking how many samples the window holds.
// full rises in the same update that the count reaches LEN.
module boxcar_fill_cnt
  import boxcar_pkg::*;
#(
  parameter int LEN = 4,
  parameter int CW  = cnt_width(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          full
);

  logic [CW-1:0] cnt_r;
  logic          full_r;
  logic          at_max_s;
  logic          at_last_s;

  assign at_max_s  = (cnt_r == CW'(LEN));
  assign at_last_s = (cnt_r == CW'(LEN - 1));

  // count accepted samples, holding at LEN instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      full_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {CW{1'b0}};
      full_r <= 1'b0;
    end else if (en && !at_max_s) begin
      cnt_r  <= cnt_r + CW'(1);
      full_r <= full_r | at_last_s;
    end else begin
      cnt_r  <= cnt_r;
      full_r <= full_r;
    end
  end

  assign cnt  = cnt_r;
  assign full = full_r;

endmodule

// File: rtl/boxcar_accum.sv
// Running-window (boxcar) sum of the last LEN accepted samples.
// Optional build macro BOXCAR_AVG_EN adds a registered avg = sum / LEN output.
module boxcar_accum
  import boxcar_pkg::*;
#(
  parameter  int DW  = 8,
  parameter  int LEN = 4,
  localparam int OW  = sum_width(DW, LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] dly_in,
  output logic [OW-1:0] sum,
  output logic          full,
  output logic          vld
`ifdef BOXCAR_AVG_EN
  ,output logic [DW-1:0] avg
`endif
);

  localparam int CW = cnt_width(LEN);

  if (LEN < 1) begin : g_len_min
    $error("boxcar_accum: LEN must be >= 1");
  end

  state_t        state_r;
  state_t        state_nxt_s;
  logic [OW-1:0] sum_r;
  logic [OW-1:0] sum_nxt_s;
  logic          vld_r;
  logic          vld_nxt_s;
  logic [OW-1:0] din_w_s;
  logic [OW-1:0] dly_w_s;
  logic [CW-1:0] fill_cnt_s;
  logic          full_s;
  logic          fill_last_s;

  assign din_w_s     = {{(OW-DW){1'b0}}, din};
  assign dly_w_s     = {{(OW-DW){1'b0}}, dly_in};
  assign fill_last_s = (fill_cnt_s == CW'(LEN - 1));

  boxcar_fill_cnt #(
    .LEN (LEN),
    .CW  (CW)
  ) u_fill_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .cnt  (fill_cnt_s),
    .full (full_s)
  );

  // next-state and datapath; dly_in only enters the sum once the window is full
  always_comb begin
    state_nxt_s = state_r;
    sum_nxt_s   = sum_r;
    vld_nxt_s   = 1'b0;
    if (clr) begin
      state_nxt_s = FILL;
      sum_nxt_s   = {OW{1'b0}};
    end else if (en) begin
      case (state_r)
        FILL: begin
          sum_nxt_s = sum_r + din_w_s;
          if (fill_last_s) begin
            state_nxt_s = RUN;
            vld_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = FILL;
          end
        end
        RUN: begin
          sum_nxt_s   = sum_r + din_w_s - dly_w_s;
          state_nxt_s = RUN;
          vld_nxt_s   = 1'b1;
        end
        default: begin
          state_nxt_s = FILL;
          sum_nxt_s   = {OW{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // state, sum and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
      sum_r   <= {OW{1'b0}};
      vld_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sum_r   <= sum_nxt_s;
      vld_r   <= vld_nxt_s;
    end
  end

  assign sum  = sum_r;
  assign full = full_s;
  assign vld  = vld_r;

`ifdef BOXCAR_AVG_EN
  localparam int SH = $clog2(LEN);

  if ((LEN & (LEN - 1)) != 0) begin : g_len_pow2
    $error("boxcar_accum: LEN must be a power of two when BOXCAR_AVG_EN is defined");
  end

  logic [DW-1:0] avg_r;

  // average tracks the sum update but stays zero until the window is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_r <= {DW{1'b0}};
    end else if (clr) begin
      avg_r <= {DW{1'b0}};
    end else if (vld_nxt_s) begin
      avg_r <= DW'(sum_nxt_s >> SH);
    end else begin
      avg_r <= avg_r;
    end
  end

  assign avg = avg_r;
`endif

endmodule
